// File: rtl/of_interlock_ctrl.sv
// Operand-fetch interlock controller: decodes the OF instruction, tracks
// in-flight writers in EX/MA/RW, and decides issue / stall / squash.
// Also sequences multi-cycle mul/div/mod occupancy of EX via ex_hold.
module of_interlock_ctrl #(
    parameter int MULDIV_CYCLES = 4,
    parameter int RA_REG        = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        of_valid,
    input  logic [31:0] of_instr,
    input  logic        ex_branch_taken,
    output logic        of_issue,
    output logic        stall_fetch,
    output logic        flush_of,
    output logic        ex_hold,
    output logic [15:0] busy_vec,
    output logic        flags_busy,
    output logic [1:0]  stall_cause
);
    localparam logic [3:0] RA = RA_REG[3:0];

    typedef struct packed {
        logic       vld;
        logic       wr;
        logic [3:0] rg;
        logic       cmp;
    } tag_t;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    tag_t       ex_q, ma_q, rw_q, ex_d, ma_d, rw_d;
    tag_t       of_tag;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [4:0] op;
    logic       imm;
    logic [3:0] rd, rs1, rs2;
    logic [2:0] src_v;
    logic [3:0] src_r [3];
    logic       is_muldiv, is_branch_flag;
    logic       reg_raw, flag_raw;

    assign op  = of_instr[31:27];
    assign imm = of_instr[26];
    assign rd  = of_instr[25:22];
    assign rs1 = of_instr[21:18];
    assign rs2 = of_instr[17:14];

    assign ex_hold = (state_q == S_BUSY);

    // Decode: sources read by the OF instruction and the tag it would carry into EX
    always_comb begin
        src_v          = '0;
        src_r[0]       = rs1;
        src_r[1]       = rs2;
        src_r[2]       = (op == 5'd20) ? RA : rd;
        src_v[0]       = (op <= 5'd7) || (op inside {5'd10, 5'd11, 5'd12, 5'd14, 5'd15});
        src_v[1]       = ((op <= 5'd7) || (op inside {5'd10, 5'd11, 5'd12})) && !imm;
        src_v[2]       = (op == 5'd15) || (op == 5'd20);
        is_muldiv      = op inside {5'd2, 5'd3, 5'd4};
        is_branch_flag = (op == 5'd16) || (op == 5'd17);
        of_tag         = '0;
        of_tag.vld     = 1'b1;
        of_tag.wr      = (op <= 5'd4) || (op inside {[5'd6:5'd12]}) || (op == 5'd14) || (op == 5'd19);
        of_tag.rg      = (op == 5'd19) ? RA : rd;
        of_tag.cmp     = (op == 5'd5);
    end

    // Hazard detection against every valid in-flight tag (RW included: no bypass)
    always_comb begin
        reg_raw  = 1'b0;
        flag_raw = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (src_v[s]) begin
                if (ex_q.vld && ex_q.wr && ex_q.rg == src_r[s]) reg_raw = 1'b1;
                if (ma_q.vld && ma_q.wr && ma_q.rg == src_r[s]) reg_raw = 1'b1;
                if (rw_q.vld && rw_q.wr && rw_q.rg == src_r[s]) reg_raw = 1'b1;
            end
        end
        if (is_branch_flag && ((ex_q.vld && ex_q.cmp) || (ma_q.vld && ma_q.cmp) || (rw_q.vld && rw_q.cmp)))
            flag_raw = 1'b1;
        reg_raw  = reg_raw && of_valid;
        flag_raw = flag_raw && of_valid;
    end

    // Issue decision: mul/div hold beats branch squash beats RAW stalls
    always_comb begin
        of_issue    = 1'b0;
        stall_fetch = 1'b0;
        flush_of    = 1'b0;
        stall_cause = 2'd0;
        if (ex_hold) begin
            stall_fetch = 1'b1;
            stall_cause = 2'd3;
        end else if (ex_branch_taken) begin
            flush_of = 1'b1;
        end else if (reg_raw) begin
            stall_fetch = 1'b1;
            stall_cause = 2'd1;
        end else if (flag_raw) begin
            stall_fetch = 1'b1;
            stall_cause = 2'd2;
        end else begin
            of_issue = of_valid;
        end
    end

    // Tag pipeline advance; while EX is held, a bubble drops into MA
    always_comb begin
        rw_d = ma_q;
        if (ex_hold) begin
            ex_d = ex_q;
            ma_d = '0;
        end else begin
            ex_d = of_issue ? of_tag : '0;
            ma_d = ex_q;
        end
    end

    // Pending-write summaries over valid tags
    always_comb begin
        busy_vec = '0;
        if (ex_q.vld && ex_q.wr) busy_vec[ex_q.rg] = 1'b1;
        if (ma_q.vld && ma_q.wr) busy_vec[ma_q.rg] = 1'b1;
        if (rw_q.vld && rw_q.wr) busy_vec[rw_q.rg] = 1'b1;
        flags_busy = (ex_q.vld && ex_q.cmp) || (ma_q.vld && ma_q.cmp) || (rw_q.vld && rw_q.cmp);
    end

    // Mul/div occupancy FSM: holds EX for MULDIV_CYCLES-1 cycles after issue
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (of_issue && is_muldiv && (MULDIV_CYCLES > 1)) begin
                    state_d = S_BUSY;
                    cnt_d   = 4'(MULDIV_CYCLES - 1);
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any mul/div and empties the tag pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            ma_q    <= '0;
            rw_q    <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            ma_q    <= ma_d;
            rw_q    <= rw_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_of_interlock_ctrl.sv
// Bench for of_interlock_ctrl: directed scenarios then random traffic, all
// compared each cycle against a lifetime-counter model of the pipeline.
module tb_of_interlock_ctrl;
    localparam int MC = 4;
    localparam int RA = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        of_valid = 1'b0;
    logic [31:0] of_instr = '0;
    logic        ex_branch_taken = 1'b0;
    logic        of_issue, stall_fetch, flush_of, ex_hold, flags_busy;
    logic [15:0] busy_vec;
    logic [1:0]  stall_cause;

    of_interlock_ctrl #(.MULDIV_CYCLES(MC), .RA_REG(RA)) dut (
        .clk(clk), .rst_n(rst_n), .of_valid(of_valid), .of_instr(of_instr),
        .ex_branch_taken(ex_branch_taken), .of_issue(of_issue),
        .stall_fetch(stall_fetch), .flush_of(flush_of), .ex_hold(ex_hold),
        .busy_vec(busy_vec), .flags_busy(flags_busy), .stall_cause(stall_cause)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: cycles each register / the flags stay pending, and hold cycles left
    int reg_life [16];
    int flag_life;
    int hold_rem;
    logic        e_issue, e_stall, e_flush, e_hold, e_fbusy;
    logic [15:0] e_busy;
    logic [1:0]  e_cause;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int i, input int rd, input int rs1, input int rs2);
        logic [31:0] w;
        w = '0;
        w[31:27] = op[4:0];
        w[26]    = i[0];
        w[25:22] = rd[3:0];
        w[21:18] = rs1[3:0];
        w[17:14] = rs2[3:0];
        return w;
    endfunction

    task automatic model_clear();
        for (int n = 0; n < 16; n++) reg_life[n] = 0;
        flag_life = 0;
        hold_rem  = 0;
    endtask

    task automatic model_eval();
        int op, im, rd, rs1, rs2;
        int src[$];
        logic raw, fraw;
        op = int'(of_instr[31:27]); im = int'(of_instr[26]);
        rd = int'(of_instr[25:22]); rs1 = int'(of_instr[21:18]); rs2 = int'(of_instr[17:14]);
        if (op <= 7 || (op >= 10 && op <= 12) || op == 14 || op == 15) src.push_back(rs1);
        if ((op <= 7 || (op >= 10 && op <= 12)) && im == 0) src.push_back(rs2);
        if (op == 15) src.push_back(rd);
        if (op == 20) src.push_back(RA);
        raw = 1'b0;
        foreach (src[k]) if (reg_life[src[k]] > 0) raw = 1'b1;
        fraw = (op == 16 || op == 17) && flag_life > 0;
        raw  = raw && of_valid;
        fraw = fraw && of_valid;
        for (int n = 0; n < 16; n++) e_busy[n] = reg_life[n] > 0;
        e_fbusy = flag_life > 0;
        e_hold  = hold_rem > 0;
        e_issue = 1'b0; e_stall = 1'b0; e_flush = 1'b0; e_cause = 2'd0;
        if (e_hold) begin e_stall = 1'b1; e_cause = 2'd3; end
        else if (ex_branch_taken) e_flush = 1'b1;
        else if (raw) begin e_stall = 1'b1; e_cause = 2'd1; end
        else if (fraw) begin e_stall = 1'b1; e_cause = 2'd2; end
        else e_issue = of_valid;
    endtask

    // An issued instruction lingers 3 cycles (EX, MA, RW), plus MC-1 if it holds EX
    task automatic model_edge();
        int op, life;
        op = int'(of_instr[31:27]);
        for (int n = 0; n < 16; n++) if (reg_life[n] > 0) reg_life[n]--;
        if (flag_life > 0) flag_life--;
        if (hold_rem > 0) hold_rem--;
        if (e_issue) begin
            life = (op >= 2 && op <= 4) ? 3 + MC - 1 : 3;
            if (op <= 4 || (op >= 6 && op <= 12) || op == 14) reg_life[int'(of_instr[25:22])] = life;
            if (op == 19) reg_life[RA] = life;
            if (op == 5) flag_life = life;
            if (op >= 2 && op <= 4 && MC > 1) hold_rem = MC - 1;
        end
    endtask

    // One cycle: compare all outputs mid-cycle, then take the edge
    task automatic step();
        #3;
        if (!rst_n) model_clear();
        model_eval();
        check("of_issue", of_issue, e_issue);
        check("stall_fetch", stall_fetch, e_stall);
        check("flush_of", flush_of, e_flush);
        check("ex_hold", ex_hold, e_hold);
        check("busy_vec", busy_vec, e_busy);
        check("flags_busy", flags_busy, e_fbusy);
        check("stall_cause", stall_cause, e_cause);
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic bt);
        of_valid = v; of_instr = ins; ex_branch_taken = bt;
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 8; k++) begin drive(1'b1, mk(13, 0, 0, 0, 0), 1'b0); step(); end
    endtask

    initial begin
        logic [31:0] ins;
        model_clear();
        // Reset state with add r1,r2,r3 waiting in OF
        drive(1'b1, mk(0, 0, 1, 2, 3), 1'b0);
        check("rst_ex_hold", ex_hold, 1'b0);
        check("rst_busy_vec", busy_vec, 16'h0000);
        check("rst_of_issue", of_issue, 1'b1);
        step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, mk(13, 0, 0, 0, 0), 1'b0);
            check("add_busy_vec", busy_vec, (k < 3) ? 32'h0002 : 32'h0000);
            step();
        end
        // Register RAW: sub r4,r1,r5 behind add r1
        drive(1'b1, mk(0, 0, 1, 2, 3), 1'b0); step();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, mk(1, 0, 4, 1, 5), 1'b0);
            check("raw_stall", stall_fetch, (k < 3) ? 1'b1 : 1'b0);
            check("raw_cause", stall_cause, (k < 3) ? 2'd1 : 2'd0);
            step();
        end
        drain();
        // mul holds EX for MC-1 cycles; independent add waits for it
        drive(1'b1, mk(2, 0, 2, 3, 4), 1'b0); step();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, mk(0, 0, 5, 6, 7), 1'b0);
            check("mul_hold", ex_hold, (k < 3) ? 1'b1 : 1'b0);
            check("mul_cause", stall_cause, (k < 3) ? 2'd3 : 2'd0);
            check("mul_add_issue", of_issue, (k < 3) ? 1'b0 : 1'b1);
            step();
        end
        drain();
        // Flags RAW: cmp r1,r2 then beq
        drive(1'b1, mk(5, 0, 0, 1, 2), 1'b0); step();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, mk(16, 0, 0, 0, 0), 1'b0);
            check("flag_cause", stall_cause, (k < 3) ? 2'd2 : 2'd0);
            check("flag_busy", flags_busy, (k < 3) ? 1'b1 : 1'b0);
            step();
        end
        drain();
        // Taken branch squashes a hazarding sub; EX gets a bubble
        drive(1'b1, mk(0, 0, 1, 2, 3), 1'b0); step();
        drive(1'b1, mk(1, 0, 4, 1, 5), 1'b1);
        check("br_flush", flush_of, 1'b1);
        check("br_stall", stall_fetch, 1'b0);
        check("br_issue", of_issue, 1'b0);
        step();
        drive(1'b1, mk(13, 0, 0, 0, 0), 1'b0);
        check("br_bubble_busy", busy_vec, 16'h0002);
        step();
        drain();
        // Reset in the middle of a mul
        drive(1'b1, mk(3, 0, 2, 3, 4), 1'b0); step();
        drive(1'b1, mk(13, 0, 0, 0, 0), 1'b0); step();
        rst_n = 1'b0;
        #1;
        check("midrst_hold", ex_hold, 1'b0);
        check("midrst_busy", busy_vec, 16'h0000);
        model_clear();
        step();
        rst_n = 1'b1;
        step();
        drive(1'b1, mk(13, 0, 0, 0, 0), 1'b0);
        check("postrst_hold", ex_hold, 1'b0);
        step();
        // Random traffic; OF keeps its instruction while fetch is stalled
        ins = mk(0, 0, 1, 2, 3);
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 9) != 0), ins, ($urandom_range(0, 9) == 0));
            step();
            if (!e_stall)
                ins = mk($urandom_range(0, 23), $urandom_range(0, 1),
                         ($urandom_range(0, 4) == 4) ? 15 : $urandom_range(0, 3),
                         ($urandom_range(0, 4) == 4) ? 15 : $urandom_range(0, 3),
                         ($urandom_range(0, 4) == 4) ? 15 : $urandom_range(0, 3));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
